// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: memory command codes and arbiter FSM states.
package mem_defines;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    // 2'b11 is not a legal command and must never win a grant.
    function automatic logic is_access(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// Read tag delay line: carries {valid, port_id} alongside the RAM read latency
// so returning data can be steered to the requester that issued it.
module rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_port,
    output logic o_valid,
    output logic o_port
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_port;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_port  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_port[0]  <= i_port;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_port[i]  <= r_port[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_port  = r_port[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared program/data RAM, with bounded
// burst ownership, registered RAM command and tagged read-data return.
module mem_arbiter
    import mem_defines::*;
#(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req0_cmd,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req0_lock,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic [1:0]    req1_cmd,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    input  logic          req1_lock,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    o_state
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t    r_state, w_next_state;
    logic          r_rr_ptr, w_next_rr;
    logic [CW-1:0] r_lock_cnt, w_next_cnt;
    logic          w_req0, w_req1, w_gnt0, w_gnt1;
    logic          w_own1, w_own_req, w_own_lock;
    logic          r_mem_port;
    logic          w_tag_valid, w_tag_port;
    logic [DW-1:0] r_rdata;

    assign w_req0     = is_access(req0_cmd);
    assign w_req1     = is_access(req1_cmd);
    assign w_own1     = (r_state == OWN1);
    assign w_own_req  = w_own1 ? w_req1 : w_req0;
    assign w_own_lock = w_own1 ? req1_lock : req0_lock;

    // lock_cnt counts grants of the current ownership including the one being
    // given, so the owner gets at most MAX_LOCK back-to-back grants.
    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_next_state = r_state;
        w_next_rr    = r_rr_ptr;
        w_next_cnt   = r_lock_cnt;
        case (r_state)
            IDLE: begin
                if (w_req0 && (!w_req1 || !r_rr_ptr)) begin
                    w_gnt0 = 1'b1;
                end else if (w_req1) begin
                    w_gnt1 = 1'b1;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_next_rr = w_gnt0;
                end
                if (MAX_LOCK > 1) begin
                    if (w_gnt0 && req0_lock) begin
                        w_next_state = OWN0;
                        w_next_cnt   = CW'(1);
                    end else if (w_gnt1 && req1_lock) begin
                        w_next_state = OWN1;
                        w_next_cnt   = CW'(1);
                    end
                end
            end
            OWN0, OWN1: begin
                if (w_own_req) begin
                    w_gnt0 = !w_own1;
                    w_gnt1 = w_own1;
                    if (!w_own_lock || r_lock_cnt >= CW'(MAX_LOCK - 1)) begin
                        w_next_state = IDLE;
                        w_next_cnt   = '0;
                        w_next_rr    = !w_own1;
                    end else begin
                        w_next_cnt = r_lock_cnt + CW'(1);
                    end
                end else begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_rr_ptr   <= w_next_rr;
            r_lock_cnt <= w_next_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_cmd    <= MNONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r_mem_port <= 1'b0;
        end else if (w_gnt0 || w_gnt1) begin
            mem_cmd    <= w_gnt1 ? req1_cmd   : req0_cmd;
            mem_addr   <= w_gnt1 ? req1_addr  : req0_addr;
            mem_wdata  <= w_gnt1 ? req1_wdata : req0_wdata;
            r_mem_port <= w_gnt1;
        end else begin
            mem_cmd <= MNONE;
        end
    end

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (mem_cmd == MREAD),
        .i_port  (r_mem_port),
        .o_valid (w_tag_valid),
        .o_port  (w_tag_port)
    );

    // rdata passes the RAM word through on the return cycle and holds it after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (w_tag_valid) begin
            r_rdata <= mem_rdata;
        end
    end

    assign rdata   = w_tag_valid ? mem_rdata : r_rdata;
    assign rvalid0 = w_tag_valid & ~w_tag_port;
    assign rvalid1 = w_tag_valid & w_tag_port;
    assign gnt0    = w_gnt0 & reset;
    assign gnt1    = w_gnt1 & reset;
    assign o_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM model, read-return scoreboard and
// grant/command checks across arbitration, lock and reset scenarios.
module tb_mem_arbiter;
    import mem_defines::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req0_cmd, req1_cmd;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_lock, req1_lock;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    dbg_state;

    logic [DW-1:0] ram [0:511];
    logic [511:0]  ram_written = '0;

    int errors = 0;
    int checks = 0;
    logic [DW:0] exp_q[$];

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_LOCK(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_cmd   (req0_cmd),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_lock  (req0_lock),
        .gnt0       (gnt0),
        .rvalid0    (rvalid0),
        .req1_cmd   (req1_cmd),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_lock  (req1_lock),
        .gnt1       (gnt1),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .o_state    (dbg_state)
    );

    // ---------------- clock / RAM model ----------------
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 9'h005) return 16'hABCD;
        return ({7'b0, a} * 16'd37) ^ 16'hC3A5;
    endfunction

    // One-cycle-latency synchronous RAM; untouched words read their initial pattern.
    always @(posedge clk) begin
        if (mem_cmd == MWRITE) begin
            ram[mem_addr]         <= mem_wdata;
            ram_written[mem_addr] <= 1'b1;
        end
        if (mem_cmd == MREAD) begin
            mem_rdata <= ram_written[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every read return is popped in issue order.
    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            check("rvalid_exclusive", {31'b0, rvalid0 & rvalid1}, 32'd0);
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", {30'b0, rvalid1, rvalid0}, 32'd0);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("rd_port", {31'b0, rvalid1}, {31'b0, e[DW]});
                check("rd_data", {16'b0, rdata}, {16'b0, e[DW-1:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive0(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        req0_cmd = c; req0_addr = a; req0_wdata = d; req0_lock = l;
    endtask

    task automatic drive1(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        req1_cmd = c; req1_addr = a; req1_wdata = d; req1_lock = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gnt_is(input string tag, input logic e0, input logic e1);
        check({tag, "_gnt0"}, {31'b0, gnt0}, {31'b0, e0});
        check({tag, "_gnt1"}, {31'b0, gnt1}, {31'b0, e1});
    endtask

    task automatic step_gnt(input string tag, input logic e0, input logic e1);
        @(negedge clk);
        gnt_is(tag, e0, e1);
        tick();
    endtask

    task automatic push_rd(input logic port, input logic [AW-1:0] a);
        exp_q.push_back({port, init_word(a)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n0;
        int n1;
        int g;
        reset = 1'b1;
        drive0(MNONE, '0, '0, 1'b0);
        drive1(MNONE, '0, '0, 1'b0);
        #2 reset = 1'b0;

        // 1: reset held with random requests
        for (int k = 0; k < 8; k++) begin
            drive0(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)), 16'($urandom), 1'($urandom_range(0, 1)));
            drive1(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)), 16'($urandom), 1'($urandom_range(0, 1)));
            @(negedge clk);
            check("rst_mem_cmd", {30'b0, mem_cmd}, {30'b0, MNONE});
            gnt_is("rst", 1'b0, 1'b0);
            check("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
            tick();
        end
        drive0(MNONE, '0, '0, 1'b0);
        drive1(MNONE, '0, '0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
        check("rst_rdata", {16'b0, rdata}, 32'd0);
        tick();

        // 2: single port0 read with exact return timing, then a port1 read
        drive0(MREAD, 9'h005, '0, 1'b0);
        push_rd(1'b0, 9'h005);
        step_gnt("t2_rd0", 1'b1, 1'b0);
        drive0(MNONE, '0, '0, 1'b0);
        @(negedge clk);
        check("t2_mem_cmd", {30'b0, mem_cmd}, {30'b0, MREAD});
        check("t2_mem_addr", {23'b0, mem_addr}, 32'h005);
        check("t2_rvalid_early", {31'b0, rvalid0}, 32'd0);
        tick();
        @(negedge clk);
        check("t2_rvalid0", {31'b0, rvalid0}, 32'd1);
        check("t2_rvalid1", {31'b0, rvalid1}, 32'd0);
        check("t2_rdata", {16'b0, rdata}, 32'h0000ABCD);
        tick();
        drive1(MREAD, 9'h0A3, '0, 1'b0);
        push_rd(1'b1, 9'h0A3);
        step_gnt("t2_rd1", 1'b0, 1'b1);
        drive1(MNONE, '0, '0, 1'b0);
        repeat (3) step_gnt("t2_idle", 1'b0, 1'b0);

        // 3: both ports reading continuously, no lock -> strict alternation
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            drive0(MREAD, 9'(9'h020 + n0), '0, 1'b0);
            drive1(MREAD, 9'(9'h040 + n1), '0, 1'b0);
            if (k % 2 == 0) begin
                push_rd(1'b0, 9'(9'h020 + n0));
                step_gnt("t3_rr", 1'b1, 1'b0);
                n0++;
            end else begin
                push_rd(1'b1, 9'(9'h040 + n1));
                step_gnt("t3_rr", 1'b0, 1'b1);
                n1++;
            end
        end
        drive0(MNONE, '0, '0, 1'b0);
        drive1(MNONE, '0, '0, 1'b0);
        repeat (3) step_gnt("t3_idle", 1'b0, 1'b0);

        // 4: port1 locked write burst blocks port0 until released
        drive1(MWRITE, 9'h010, 16'h1234, 1'b1);
        step_gnt("t4_w1", 1'b0, 1'b1);
        drive0(MREAD, 9'h030, '0, 1'b0);
        @(negedge clk);
        check("t4_mem_cmd", {30'b0, mem_cmd}, {30'b0, MWRITE});
        check("t4_mem_addr", {23'b0, mem_addr}, 32'h010);
        check("t4_mem_wdata", {16'b0, mem_wdata}, 32'h1234);
        check("t4_state", {30'b0, dbg_state}, {30'b0, OWN1});
        gnt_is("t4_lock", 1'b0, 1'b1);
        tick();
        repeat (3) step_gnt("t4_lock", 1'b0, 1'b1);
        drive1(MWRITE, 9'h010, 16'h1234, 1'b0);
        step_gnt("t4_unlock", 1'b0, 1'b1);
        drive1(MNONE, '0, '0, 1'b0);
        push_rd(1'b0, 9'h030);
        @(negedge clk);
        check("t4_state_idle", {30'b0, dbg_state}, {30'b0, IDLE});
        gnt_is("t4_p0", 1'b1, 1'b0);
        tick();
        drive0(MNONE, '0, '0, 1'b0);
        repeat (2) step_gnt("t4_idle", 1'b0, 1'b0);

        // 5: port0 lock held for 20 requests; forced release after 8 grants
        g = 0;
        drive0(MREAD, 9'(9'h050 + g), '0, 1'b1);
        push_rd(1'b0, 9'(9'h050 + g));
        step_gnt("t5_own", 1'b1, 1'b0);
        g++;
        drive1(MREAD, 9'h060, '0, 1'b0);
        while (g < 8) begin
            drive0(MREAD, 9'(9'h050 + g), '0, 1'b1);
            push_rd(1'b0, 9'(9'h050 + g));
            step_gnt("t5_own", 1'b1, 1'b0);
            g++;
        end
        drive0(MREAD, 9'(9'h050 + g), '0, 1'b1);
        push_rd(1'b1, 9'h060);
        @(negedge clk);
        check("t5_released", {30'b0, dbg_state}, {30'b0, IDLE});
        gnt_is("t5_p1", 1'b0, 1'b1);
        tick();
        drive1(MNONE, '0, '0, 1'b0);
        while (g < 20) begin
            drive0(MREAD, 9'(9'h050 + g), '0, 1'b1);
            push_rd(1'b0, 9'(9'h050 + g));
            step_gnt("t5_tail", 1'b1, 1'b0);
            g++;
        end
        drive0(MNONE, '0, '0, 1'b0);
        @(negedge clk);
        check("t5_still_own", {30'b0, dbg_state}, {30'b0, OWN0});
        gnt_is("t5_drop", 1'b0, 1'b0);
        tick();
        @(negedge clk);
        check("t5_idle", {30'b0, dbg_state}, {30'b0, IDLE});
        tick();
        repeat (2) step_gnt("t5_drain", 1'b0, 1'b0);

        // 6: reset one cycle after a read grant drops the pending return
        drive0(MREAD, 9'h070, '0, 1'b0);
        step_gnt("t6_rd", 1'b1, 1'b0);
        drive0(MNONE, '0, '0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("t6_mem_cmd", {30'b0, mem_cmd}, {30'b0, MNONE});
        check("t6_state", {30'b0, dbg_state}, {30'b0, IDLE});
        check("t6_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
        tick();
        @(negedge clk);
        check("t6_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
        tick();
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t6_post_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
            tick();
        end

        @(negedge clk);
        check("ram_write", {16'b0, ram[9'h010]}, 32'h1234);
        check("q_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
